// File: rtl/datapath_accumulator_if.sv
// datapath_accumulator_if
// Bundles the beat-input and result-output handshakes of the datapath
// accumulator so the block and its neighbours connect through one port.
//   master : upstream/consumer side (drives beats and out_ready)
//   slave  : the accumulator itself
// Signals:
//   in_valid, in_ready, in_y[N], in_co, len[CNT_W], relu_en  - beat input
//   out_valid, out_ready, out_y[N], out_sat, out_co         - result output
interface datapath_accumulator_if #(
  parameter int N     = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_y;
  logic             in_co;
  logic [CNT_W-1:0] len;
  logic             relu_en;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_y;
  logic             out_sat;
  logic             out_co;

  modport master (
    output in_valid, in_y, in_co, len, relu_en, out_ready,
    input  in_ready, out_valid, out_y, out_sat, out_co
  );

  modport slave (
    input  in_valid, in_y, in_co, len, relu_en, out_ready,
    output in_ready, out_valid, out_y, out_sat, out_co
  );
endinterface

// File: rtl/datapath_accumulator.sv
// datapath_accumulator
// Accumulates a programmable number of signed datapath results into a wide
// signed register, then saturates the sum to N bits, optionally applies ReLU,
// and holds the result on a registered valid/ready output until taken.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - datapath_accumulator_if.slave (beat input and result output)
module datapath_accumulator #(
  parameter int N     = 16,
  parameter int CNT_W = 8,
  parameter int ACC_W = 24
) (
  input logic                   clk,
  input logic                   rst_n,
  datapath_accumulator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  localparam int MAX_I = (1 << (N - 1)) - 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(MAX_I);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  state_t                   state, state_next;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         len_q;
  logic                     relu_q;
  logic                     co_q;
  logic [N-1:0]             out_y_q;
  logic                     out_sat_q;
  logic                     out_co_q;

  logic                     accept;
  logic [CNT_W-1:0]         eff_len;
  logic signed [ACC_W-1:0]  y_ext;
  logic signed [ACC_W-1:0]  sum_next;
  logic                     co_next;
  logic                     relu_sel;
  logic                     last_beat;
  logic                     sat_hi, sat_lo;
  logic [N-1:0]             res_y;

  // in_ready depends only on the registered state, never on in_valid/out_ready
  assign bus.in_ready  = (state != OUT);
  assign bus.out_valid = (state == OUT);
  assign bus.out_y     = out_y_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_co    = out_co_q;

  // The first beat of a sum loads rather than adds, and takes len/relu_en
  // straight from the bus because they have not been latched yet.
  always_comb begin
    accept    = bus.in_valid && bus.in_ready;
    eff_len   = (bus.len == '0) ? CNT_W'(1) : bus.len;
    y_ext     = {{(ACC_W - N){bus.in_y[N-1]}}, bus.in_y};
    sum_next  = acc + y_ext;
    co_next   = co_q | bus.in_co;
    relu_sel  = relu_q;
    last_beat = ((cnt + CNT_W'(1)) == len_q);
    if (state == IDLE) begin
      sum_next  = y_ext;
      co_next   = bus.in_co;
      relu_sel  = bus.relu_en;
      last_beat = (eff_len == CNT_W'(1));
    end

    sat_hi = (sum_next > SAT_MAX);
    sat_lo = (sum_next < SAT_MIN);
    res_y  = sum_next[N-1:0];
    if (sat_hi) res_y = {1'b0, {(N - 1){1'b1}}};
    if (sat_lo) res_y = {1'b1, {(N - 1){1'b0}}};
    // ReLU is applied after the clamp, so out_sat still reports the clamp
    if (relu_sel && res_y[N-1]) res_y = '0;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = last_beat ? OUT : ACC;
      ACC:     if (accept && last_beat) state_next = OUT;
      OUT:     if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Accumulator, term counter, sticky carry flag and the registered result.
  // The result fields are only written on the beat that completes a sum, so
  // they stay frozen for the whole OUT state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      len_q     <= '0;
      relu_q    <= 1'b0;
      co_q      <= 1'b0;
      out_y_q   <= '0;
      out_sat_q <= 1'b0;
      out_co_q  <= 1'b0;
    end else if (accept) begin
      acc  <= sum_next;
      co_q <= co_next;
      if (state == IDLE) begin
        cnt    <= CNT_W'(1);
        len_q  <= eff_len;
        relu_q <= bus.relu_en;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (last_beat) begin
        out_y_q   <= res_y;
        out_sat_q <= sat_hi || sat_lo;
        out_co_q  <= co_next;
      end
    end else if (state == OUT && bus.out_ready) begin
      acc  <= '0;
      cnt  <= '0;
      co_q <= 1'b0;
    end
  end

endmodule
